mem_io_fabric: RTL and testbench
================================

# mem_io_fabric

Parametrised data-side bus fabric between the CPU data port and the data RAM and IO peripherals. It replaces the fixed combinational RAM/IO decode. Each access is a registered request/ready transaction with:
- one decoded strobe per peripheral slot;
- selected-slot read muxing instead of an OR of every peripheral output;
- configurable IO wait states;
- a bus-error response plus a sticky fault-address capture for unmapped accesses.

## Interface
Parameters:
- RAM_BASE, 16'h0000, RAM region base; aligned to 2^RAM_AW
- RAM_AW, 11, RAM address width (2 KiB)
- IO_BASE, 16'h1000, IO region base; aligned to NUM_SLOTS*2^SLOT_AW
- NUM_SLOTS, 8, peripheral slot count (1..16)
- SLOT_AW, 5, address width inside each slot (32 bytes per slot)
- IO_WAIT, 1, extra wait cycles on IO accesses (0..15)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  request; held stable until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  16  byte address
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data; valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  bus error; valid with cpu_ready
- ram_we, ram_re  out  1  RAM strobes
- ram_addr  out  RAM_AW  RAM address
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data; valid the cycle after ram_re
- io_we, io_re  out  NUM_SLOTS  one-hot slot strobes
- io_addr  out  SLOT_AW  offset within the slot
- io_wdata  out  8  IO write data
- io_rdata  in  8*NUM_SLOTS  slot read data; slot i is [8i+7:8i]
- fault_valid  out  1  sticky: an unmapped access occurred
- fault_addr  out  16  address of the first unmapped access
- fault_clr  in  1  clears fault_valid

## Operation
- FSM states: IDLE, RAM_ACC, IO_ACC, IO_WAIT_ST, RESP.
- IDLE: when cpu_req=1, latch cpu_addr, cpu_we and cpu_wdata, then decode:
  - RAM: RAM_BASE <= addr < RAM_BASE + 2^RAM_AW. Go to RAM_ACC.
  - IO: IO_BASE <= addr < IO_BASE + NUM_SLOTS*2^SLOT_AW. Slot = (addr - IO_BASE) >> SLOT_AW. Go to IO_ACC.
  - Anything else is unmapped. Go to RESP with err=1.
- RAM_ACC: assert ram_we or ram_re for exactly one cycle with the latched address and data. Next state is RESP; on a read, RESP captures ram_rdata.
- IO_ACC: assert only the selected slot's io_we or io_re bit, for exactly one cycle. If IO_WAIT=0, go to RESP. Otherwise load the wait counter with IO_WAIT and go to IO_WAIT_ST.
- IO_WAIT_ST: decrement the counter; go to RESP when it reaches 1.
- Read-data capture:
  - On entering RESP, cpu_rdata loads from the selected slice only: ram_rdata, or io_rdata[8*slot+:8] sampled on the last IO_WAIT_ST cycle (or in the cycle after IO_ACC when IO_WAIT=0).
  - Writes and errors load cpu_rdata with 0.
- RESP: cpu_ready=1 for one cycle, cpu_err as decoded, then return to IDLE.
  - A new request is accepted no earlier than the cycle after RESP. The CPU deasserts or changes cpu_req after seeing ready.
- Fault capture:
  - An unmapped access with fault_valid=0 sets fault_valid and loads fault_addr.
  - An unmapped access with fault_valid=1 leaves fault_addr unchanged (first fault is kept).
  - fault_clr=1 clears fault_valid.
  - If fault_clr=1 and a new fault capture happen in the same cycle, the capture wins: fault_valid=1, fault_addr = new address.
- Address widths:
  - ram_addr = (addr - RAM_BASE)[RAM_AW-1:0].
  - io_addr = addr[SLOT_AW-1:0].
  - Subtractions are done in 16 bits; there is no wrap-around match past 16'hFFFF.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - cpu_ready, cpu_err, cpu_rdata, every ram/io strobe, fault_valid and fault_addr are 0.
  - ram_addr, io_addr and the wdata outputs are 0.
- Reset mid-transaction aborts it: no ready pulse follows, and a strobe already issued is not repeated.
- Latency is measured from the edge that samples cpu_req in IDLE (edge 0):
  - RAM access: strobe in the cycle after edge 0; cpu_ready in the cycle after edge 1. Total 2 cycles.
  - IO access: 2 + IO_WAIT cycles.
  - Unmapped access: cpu_ready in the cycle after edge 0. Total 1 cycle.
- Strobes are registered outputs, never combinational from cpu_addr.
- At most one strobe bit across ram_*/io_* is high in any cycle.
- Back-to-back throughput: one RAM transaction per 3 cycles, because IDLE is visited between transactions.

## Test plan
- RAM round trip: write 8'hA5 to 16'h07FF, then read 16'h07FF.
  - ram_we pulses once with ram_addr=11'h7FF.
  - The read returns cpu_rdata=8'hA5 with cpu_err=0, and ready lands exactly 2 cycles after each request.
- IO slot select, IO_WAIT=2: read 16'h1025 with every io_rdata slice driven nonzero and distinct.
  - io_re=8'b0000_0010 and io_addr=5'h05.
  - cpu_rdata equals slice 1 only; ready arrives at cycle 4.
- Unmapped accesses:
  - Read 16'h0800: cpu_err=1, cpu_rdata=0, fault_addr=16'h0800, no strobe issued.
  - Then read 16'hFFFF: fault_addr stays 16'h0800.
- fault_clr coincident with a fault to 16'h1100: fault_valid stays 1 and fault_addr=16'h1100.
- Reset mid-operation: drop rst during IO_WAIT_ST of an IO read.
  - All outputs read 0 and no cpu_ready pulse appears.
  - After release, a RAM read completes normally.
- Region boundaries:
  - 16'h10FF (slot 7, offset 31) is mapped.
  - 16'h1100 is unmapped.
  - 16'h0FFF is unmapped.

Source files
------------

// File: rtl/mem_io_fabric.sv
// -----------------------------------------------------------------------------
// mem_io_fabric
//
// Data-side bus fabric between the CPU data port and the data RAM / IO
// peripheral slots. Each CPU access is a registered request/ready transaction:
// the address is latched and decoded in IDLE, exactly one registered strobe is
// issued to RAM or to the selected IO slot, and a one-cycle ready pulse
// completes the access. Unmapped addresses complete with a bus error and are
// logged in a sticky fault-address register (first fault kept).
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   cpu_req      request, held until cpu_ready
//   cpu_we       1 = write, 0 = read
//   cpu_addr     16-bit byte address
//   cpu_wdata    write data
//   cpu_rdata    read data, valid while cpu_ready = 1 (0 otherwise)
//   cpu_ready    one-cycle completion pulse
//   cpu_err      bus error, valid with cpu_ready
//   ram_we/re    RAM strobes (one cycle)
//   ram_addr     RAM word offset
//   ram_wdata    RAM write data
//   ram_rdata    RAM read data, valid the cycle after ram_re
//   io_we/re     one-hot slot strobes (one cycle)
//   io_addr      offset within the slot
//   io_wdata     IO write data
//   io_rdata     concatenated slot read data, slot i at [8i+7:8i]
//   fault_valid  sticky unmapped-access flag
//   fault_addr   address of the first unmapped access
//   fault_clr    clears fault_valid (a same-cycle capture takes priority)
// -----------------------------------------------------------------------------
module mem_io_fabric #(
  parameter logic [15:0] RAM_BASE  = 16'h0000,
  parameter int unsigned RAM_AW    = 11,
  parameter logic [15:0] IO_BASE   = 16'h1000,
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned SLOT_AW   = 5,
  parameter int unsigned IO_WAIT   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [15:0]            cpu_addr,
  input  logic [7:0]             cpu_wdata,
  output logic [7:0]             cpu_rdata,
  output logic                   cpu_ready,
  output logic                   cpu_err,
  output logic                   ram_we,
  output logic                   ram_re,
  output logic [RAM_AW-1:0]      ram_addr,
  output logic [7:0]             ram_wdata,
  input  logic [7:0]             ram_rdata,
  output logic [NUM_SLOTS-1:0]   io_we,
  output logic [NUM_SLOTS-1:0]   io_re,
  output logic [SLOT_AW-1:0]     io_addr,
  output logic [7:0]             io_wdata,
  input  logic [8*NUM_SLOTS-1:0] io_rdata,
  output logic                   fault_valid,
  output logic [15:0]            fault_addr,
  input  logic                   fault_clr
);

  typedef enum logic [2:0] {
    IDLE,
    RAM_ACC,
    IO_ACC,
    IO_WAIT_ST,
    RESP
  } state_e;

  localparam int unsigned SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [16:0] RAM_SIZE = 17'(1) << RAM_AW;
  localparam logic [16:0] IO_SIZE  = 17'(NUM_SLOTS) << SLOT_AW;

  // ---------------------------------------------------------------------------
  // Address decode. The offsets are computed with a 17th borrow bit, so an
  // address below a region base becomes a huge offset and can never match;
  // there is no wrap-around past 16'hFFFF.
  // ---------------------------------------------------------------------------
  logic [16:0]       ram_diff;
  logic [16:0]       io_diff;
  logic              ram_hit;
  logic              io_hit;
  logic [SLOT_W-1:0] req_slot;

  assign ram_diff = {1'b0, cpu_addr} - {1'b0, RAM_BASE};
  assign io_diff  = {1'b0, cpu_addr} - {1'b0, IO_BASE};
  assign ram_hit  = (ram_diff < RAM_SIZE);
  assign io_hit   = (io_diff < IO_SIZE);
  assign req_slot = io_diff[SLOT_AW +: SLOT_W];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                 state_q,       state_d;
  logic                   we_q,          we_d;
  logic                   is_ram_q,      is_ram_d;
  logic                   err_q,         err_d;
  logic [SLOT_W-1:0]      slot_q,        slot_d;
  logic [3:0]             wait_q,        wait_d;
  logic [7:0]             rdata_q,       rdata_d;
  logic                   ram_we_q,      ram_we_d;
  logic                   ram_re_q,      ram_re_d;
  logic [RAM_AW-1:0]      ram_addr_q,    ram_addr_d;
  logic [NUM_SLOTS-1:0]   io_we_q,       io_we_d;
  logic [NUM_SLOTS-1:0]   io_re_q,       io_re_d;
  logic [SLOT_AW-1:0]     io_addr_q,     io_addr_d;
  logic [7:0]             wdata_q,       wdata_d;
  logic                   fault_valid_q, fault_valid_d;
  logic [15:0]            fault_addr_q,  fault_addr_d;

  logic [7:0]           io_slice;
  logic [NUM_SLOTS-1:0] slot_onehot;
  logic                 unmapped_req;

  assign io_slice     = io_rdata[{slot_q, 3'b000} +: 8];
  assign slot_onehot  = NUM_SLOTS'(1) << req_slot;
  assign unmapped_req = (state_q == IDLE) && cpu_req && !ram_hit && !io_hit;

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch. Strobes default low, which is
    // what makes them one-cycle pulses.
    state_d       = state_q;
    we_d          = we_q;
    is_ram_d      = is_ram_q;
    err_d         = err_q;
    slot_d        = slot_q;
    wait_d        = wait_q;
    rdata_d       = rdata_q;
    ram_we_d      = 1'b0;
    ram_re_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    io_we_d       = '0;
    io_re_d       = '0;
    io_addr_d     = io_addr_q;
    wdata_d       = wdata_q;
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          if (ram_hit) begin
            is_ram_d   = 1'b1;
            err_d      = 1'b0;
            ram_we_d   = cpu_we;
            ram_re_d   = !cpu_we;
            ram_addr_d = ram_diff[RAM_AW-1:0];
            state_d    = RAM_ACC;
          end else if (io_hit) begin
            is_ram_d  = 1'b0;
            err_d     = 1'b0;
            slot_d    = req_slot;
            io_we_d   = cpu_we ? slot_onehot : '0;
            io_re_d   = cpu_we ? '0 : slot_onehot;
            io_addr_d = cpu_addr[SLOT_AW-1:0];
            state_d   = IO_ACC;
          end else begin
            is_ram_d = 1'b0;
            err_d    = 1'b1;
            state_d  = RESP;
          end
        end
      end
      RAM_ACC: state_d = RESP;
      IO_ACC: begin
        if (IO_WAIT == 0) begin
          state_d = RESP;
        end else begin
          wait_d  = 4'(IO_WAIT);
          state_d = IO_WAIT_ST;
        end
      end
      IO_WAIT_ST: begin
        if (wait_q <= 4'd1) begin
          // Last wait cycle: the slot's read data is sampled here.
          rdata_d = we_q ? 8'h00 : io_slice;
          state_d = RESP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A capture with fault_valid already set only happens when the same cycle
    // also clears it; the new address then replaces the old one.
    if (unmapped_req && (!fault_valid_q || fault_clr)) begin
      fault_valid_d = 1'b1;
      fault_addr_d  = cpu_addr;
    end else if (fault_clr) begin
      fault_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its _d value from before the edge regardless of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      is_ram_q      <= 1'b0;
      err_q         <= 1'b0;
      slot_q        <= '0;
      wait_q        <= '0;
      rdata_q       <= '0;
      ram_we_q      <= 1'b0;
      ram_re_q      <= 1'b0;
      ram_addr_q    <= '0;
      io_we_q       <= '0;
      io_re_q       <= '0;
      io_addr_q     <= '0;
      wdata_q       <= '0;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      is_ram_q      <= is_ram_d;
      err_q         <= err_d;
      slot_q        <= slot_d;
      wait_q        <= wait_d;
      rdata_q       <= rdata_d;
      ram_we_q      <= ram_we_d;
      ram_re_q      <= ram_re_d;
      ram_addr_q    <= ram_addr_d;
      io_we_q       <= io_we_d;
      io_re_q       <= io_re_d;
      io_addr_q     <= io_addr_d;
      wdata_q       <= wdata_d;
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response. RAM data (and IO data when there are no wait cycles) only
  // becomes valid during the RESP cycle itself, so it is steered straight
  // through from the selected source; with wait cycles the IO data was
  // captured on the last wait cycle. Writes, errors and non-RESP cycles
  // return 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    cpu_rdata = 8'h00;
    if ((state_q == RESP) && !we_q && !err_q) begin
      if (is_ram_q)          cpu_rdata = ram_rdata;
      else if (IO_WAIT == 0) cpu_rdata = io_slice;
      else                   cpu_rdata = rdata_q;
    end
  end

  assign cpu_ready   = (state_q == RESP);
  assign cpu_err     = cpu_ready && err_q;
  assign ram_we      = ram_we_q;
  assign ram_re      = ram_re_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = wdata_q;
  assign io_we       = io_we_q;
  assign io_re       = io_re_q;
  assign io_addr     = io_addr_q;
  assign io_wdata    = wdata_q;
  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_mem_io_fabric.sv
// -----------------------------------------------------------------------------
// tb_mem_io_fabric
//
// Directed bench for mem_io_fabric with IO_WAIT = 2. A table of access
// records (request, expected response, latency, strobes and fault state) is
// applied in a loop; hand-written sequences cover fault_clr/capture
// collisions and a reset in the middle of an IO wait.
// -----------------------------------------------------------------------------
module tb_mem_io_fabric;

  localparam int NS = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [15:0]   cpu_addr;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic          cpu_ready, cpu_err;
  logic          ram_we, ram_re;
  logic [10:0]   ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata = 8'h00;
  logic [NS-1:0] io_we, io_re;
  logic [4:0]    io_addr;
  logic [7:0]    io_wdata;
  logic [8*NS-1:0] io_rdata;
  logic          fault_valid;
  logic [15:0]   fault_addr;
  logic          fault_clr;

  int total = 0;
  int bad   = 0;

  mem_io_fabric #(
    .RAM_BASE (16'h0000),
    .RAM_AW   (11),
    .IO_BASE  (16'h1000),
    .NUM_SLOTS(NS),
    .SLOT_AW  (5),
    .IO_WAIT  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .cpu_err    (cpu_err),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .io_we      (io_we),
    .io_re      (io_re),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .fault_valid(fault_valid),
    .fault_addr (fault_addr),
    .fault_clr  (fault_clr)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model: read data appears the cycle after ram_re.
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  // Global monitors, sampled away from the active edge.
  int ready_pulses = 0;
  int strobe_cycles = 0;
  int multi_strobe = 0;
  always @(negedge clk) begin
    if (cpu_ready) ready_pulses++;
    if ({ram_we, ram_re, io_we, io_re} != '0) strobe_cycles++;
    if ($countones({ram_we, ram_re, io_we, io_re}) > 1) multi_strobe++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One CPU access starting #1 after a rising edge with the fabric in IDLE.
  // Returns at #1 after the edge that takes the fabric back to IDLE.
  task automatic access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                        input logic clr, output logic [7:0] rd, output logic er,
                        output int lat, output logic [17:0] strobes, output int scnt,
                        output logic [15:0] saddr);
    logic        done;
    logic [17:0] cur;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1; fault_clr = clr;
    strobes = '0; scnt = 0; saddr = '0; lat = 0; rd = '0; er = 1'b0; done = 1'b0;
    @(posedge clk); #1;  // edge 0
    fault_clr = 1'b0;
    for (int n = 1; n <= 20 && !done; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      cur = {ram_we, ram_re, io_we, io_re};
      if (cur != '0) begin
        strobes |= cur;
        scnt++;
        saddr = (ram_we || ram_re) ? 16'(ram_addr) : 16'(io_addr);
      end
      if (cpu_ready) begin
        done = 1'b1; lat = n; rd = cpu_rdata; er = cpu_err;
      end
    end
    cpu_req = 1'b0;
    check("ready_within_budget", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [17:0] exp_strobes;  // {ram_we, ram_re, io_we[7:0], io_re[7:0]}
    logic [15:0] exp_saddr;
    int          exp_scnt;
    logic        exp_fv;
    logic [15:0] exp_fa;
  } vec_t;

  vec_t vecs [12];

  logic [7:0]  rd;
  logic        er;
  int          lat, scnt, pulses_before, strobes_before;
  logic [17:0] strobes;
  logic [15:0] saddr;

  initial begin
    for (int i = 0; i < NS; i++) io_rdata[8*i +: 8] = 8'hA0 | 8'(i);

    vecs[0]  = '{1'b1, 16'h07FF, 8'hA5, 8'h00, 1'b0, 2, 18'h20000, 16'h07FF, 1, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 16'h07FF, 8'h00, 8'hA5, 1'b0, 2, 18'h10000, 16'h07FF, 1, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 16'h0000, 8'h3C, 8'h00, 1'b0, 2, 18'h20000, 16'h0000, 1, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 16'h0000, 8'h00, 8'h3C, 1'b0, 2, 18'h10000, 16'h0000, 1, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 16'h1025, 8'h00, 8'hA1, 1'b0, 4, 18'h00002, 16'h0005, 1, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 16'h10FF, 8'h77, 8'h00, 1'b0, 4, 18'h08000, 16'h001F, 1, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 16'h10FF, 8'h00, 8'hA7, 1'b0, 4, 18'h00080, 16'h001F, 1, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 16'h1000, 8'h00, 8'hA0, 1'b0, 4, 18'h00001, 16'h0000, 1, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 16'h0800, 8'h00, 8'h00, 1'b1, 1, 18'h00000, 16'h0000, 0, 1'b1, 16'h0800};
    vecs[9]  = '{1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b1, 1, 18'h00000, 16'h0000, 0, 1'b1, 16'h0800};
    vecs[10] = '{1'b0, 16'h0FFF, 8'h00, 8'h00, 1'b1, 1, 18'h00000, 16'h0000, 0, 1'b1, 16'h0800};
    vecs[11] = '{1'b1, 16'h1100, 8'h55, 8'h00, 1'b1, 1, 18'h00000, 16'h0000, 0, 1'b1, 16'h0800};

    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; fault_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_zero",
          32'($countones({cpu_ready, cpu_err, cpu_rdata, ram_we, ram_re, ram_addr, ram_wdata,
                          io_we, io_re, io_addr, io_wdata, fault_valid, fault_addr})), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven accesses.
    for (int i = 0; i < 12; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er, lat, strobes, scnt, saddr);
      check($sformatf("v%0d_rdata", i),   32'(rd),      32'(vecs[i].exp_rdata));
      check($sformatf("v%0d_err", i),     32'(er),      32'(vecs[i].exp_err));
      check($sformatf("v%0d_latency", i), 32'(lat),     32'(vecs[i].exp_lat));
      check($sformatf("v%0d_strobes", i), 32'(strobes), 32'(vecs[i].exp_strobes));
      check($sformatf("v%0d_strobe_cnt", i), 32'(scnt), 32'(vecs[i].exp_scnt));
      if (vecs[i].exp_scnt != 0)
        check($sformatf("v%0d_strobe_addr", i), 32'(saddr), 32'(vecs[i].exp_saddr));
      check($sformatf("v%0d_fault_valid", i), 32'(fault_valid), 32'(vecs[i].exp_fv));
      check($sformatf("v%0d_fault_addr", i),  32'(fault_addr),  32'(vecs[i].exp_fa));
    end

    // fault_clr coincident with a new fault: the capture wins.
    access(1'b0, 16'h1100, 8'h00, 1'b1, rd, er, lat, strobes, scnt, saddr);
    check("clr_collision_err", 32'(er), 32'd1);
    check("clr_collision_fault_valid", 32'(fault_valid), 32'd1);
    check("clr_collision_fault_addr", 32'(fault_addr), 32'h1100);

    // fault_clr alone clears the flag; the next fault is captured afresh.
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    check("fault_clr_alone", 32'(fault_valid), 32'd0);
    access(1'b0, 16'h0FFF, 8'h00, 1'b0, rd, er, lat, strobes, scnt, saddr);
    check("refault_valid", 32'(fault_valid), 32'd1);
    check("refault_addr", 32'(fault_addr), 32'h0FFF);

    // Reset during IO_WAIT_ST of an IO read.
    cpu_we = 1'b0; cpu_addr = 16'h1025; cpu_req = 1'b1;
    @(posedge clk); #1;  // edge 0 -> IO_ACC, io_re asserted
    check("abort_io_re", 32'(io_re), 32'h02);
    @(posedge clk); #1;  // edge 1 -> IO_WAIT_ST
    pulses_before = ready_pulses;
    strobes_before = strobe_cycles;
    rst = 1'b0; cpu_req = 1'b0;
    #1;
    check("abort_outputs_zero",
          32'($countones({cpu_ready, cpu_err, cpu_rdata, ram_we, ram_re, ram_addr, ram_wdata,
                          io_we, io_re, io_addr, io_wdata, fault_valid, fault_addr})), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_ready", 32'(ready_pulses - pulses_before), 32'd0);
    check("abort_no_restrobe", 32'(strobe_cycles - strobes_before), 32'd0);

    access(1'b0, 16'h07FF, 8'h00, 1'b0, rd, er, lat, strobes, scnt, saddr);
    check("post_reset_rdata", 32'(rd), 32'hA5);
    check("post_reset_err", 32'(er), 32'd0);
    check("post_reset_latency", 32'(lat), 32'd2);

    check("single_strobe_always", 32'(multi_strobe), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
